// File: rtl/soin_pkg.sv
// Shared types and constants for the soin core pipeline.
// Register and data widths, register count and load funct3 encodings.
package soin_pkg;

   typedef logic [31:0] data_t;
   typedef logic [4:0]  reg_t;

   localparam int N_REG = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_unit_ld_format.sv
// Load data formatter: extracts byte/half/word at the address offset
// and sign- or zero-extends according to funct3.
module ld_format
   import soin_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic [1:0] i_off,
   input  data_t      i_rdata,
   output data_t      o_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Halfword select uses only off[1]; a misaligned off[0] is ignored.
   assign byte_v = i_rdata[{i_off, 3'b000} +: 8];
   assign half_v = i_rdata[{i_off[1], 4'b0000} +: 16];

   always_comb begin
      case (i_funct3)
         F3_LB:   o_data = {{24{byte_v[7]}}, byte_v};
         F3_LH:   o_data = {{16{half_v[15]}}, half_v};
         F3_LBU:  o_data = {24'd0, byte_v};
         F3_LHU:  o_data = {16'd0, half_v};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: merges ALU results and load responses onto the register
// file write port and tracks pending loads so decode can stall on hazards.
module wb_unit
   import soin_pkg::*;
#(
   parameter int MAX_OUTST = 2,
   parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_alu_valid,
   input  reg_t       i_alu_rd,
   input  data_t      i_alu_data,
   input  logic       i_ld_valid,
   output logic       o_ld_ready,
   input  reg_t       i_ld_rd,
   input  logic [2:0] i_ld_funct3,
   input  logic [1:0] i_ld_off,
   input  data_t      i_ld_rdata,
   input  logic       i_issue_ld,
   input  reg_t       i_issue_rd,
   input  reg_t       i_dec_rs1,
   input  reg_t       i_dec_rs2,
   input  reg_t       i_dec_rd,
   output logic       o_stall,
   output logic       o_issue_full,
   output logic       o_Wen,
   output reg_t       o_Wnum,
   output data_t      o_Wd
);

   logic             hold_v;
   reg_t             hold_rd;
   data_t            hold_data;
   data_t            fmt_data;
   logic [N_REG-1:1] pending_q;
   logic [N_REG-1:0] pend_vec;
   logic [N_REG-1:0] pend_nx;
   logic [CNT_W-1:0] cnt_q;
   logic             ld_acc;
   logic             alu_sel;
   logic             drain;
   logic             cnt_inc;

   ld_format u_ld_format (
      .i_funct3 (i_ld_funct3),
      .i_off    (i_ld_off),
      .i_rdata  (i_ld_rdata),
      .o_data   (fmt_data)
   );

   // ALU has no backpressure, so it always wins; x0 writes are dropped and
   // leave the slot free for the hold register.
   assign o_ld_ready   = ~hold_v;
   assign ld_acc       = i_ld_valid & ~hold_v;
   assign alu_sel      = i_alu_valid & (i_alu_rd != '0);
   assign drain        = ~alu_sel & hold_v;
   assign o_issue_full = (cnt_q == CNT_W'(MAX_OUTST));
   assign cnt_inc      = i_issue_ld & ~o_issue_full;
   assign pend_vec     = {pending_q, 1'b0};
   assign o_stall      = pend_vec[i_dec_rs1] | pend_vec[i_dec_rs2] |
                         pend_vec[i_dec_rd] | o_issue_full;

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      pend_nx = pend_vec;
      if (drain)
         pend_nx[hold_rd] = 1'b0;
      if (i_issue_ld && (i_issue_rd != '0))
         pend_nx[i_issue_rd] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_Wen     <= 1'b0;
         o_Wnum    <= '0;
         o_Wd      <= '0;
         hold_v    <= 1'b0;
         pending_q <= '0;
         cnt_q     <= '0;
      end else begin
         if (alu_sel) begin
            o_Wen  <= 1'b1;
            o_Wnum <= i_alu_rd;
            o_Wd   <= i_alu_data;
         end else if (hold_v) begin
            o_Wen  <= 1'b1;
            o_Wnum <= hold_rd;
            o_Wd   <= hold_data;
         end else begin
            o_Wen  <= 1'b0;
         end

         if (ld_acc && (i_ld_rd != '0))
            hold_v <= 1'b1;
         else if (drain)
            hold_v <= 1'b0;

         pending_q <= pend_nx[N_REG-1:1];

         if (cnt_inc && !ld_acc)
            cnt_q <= cnt_q + CNT_W'(1);
         else if (ld_acc && !cnt_inc && (cnt_q != '0))
            cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // NOTE: payload registers are qualified by hold_v, so they carry no reset.
   always_ff @(posedge i_clk) begin
      if (ld_acc) begin
         hold_rd   <= i_ld_rd;
         hold_data <= fmt_data;
      end
   end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Write-back stage; the writer on the register file's write port (Wen/Wnum/Wd).
- Merges single-cycle ALU results with load responses from the LSU.
- Formats load data by funct3 and byte offset.
- Keeps a per-register pending-load scoreboard so decode can stall on RAW/WAW hazards against outstanding loads.

Parameters:
- MAX_OUTST, 2, maximum outstanding (issued, not yet written-back) loads.
- CNT_W, $clog2(MAX_OUTST+1), width of outstanding-load counter.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_alu_valid  in  1  ALU result valid this cycle; no backpressure
- i_alu_rd  in  reg_t  ALU destination register
- i_alu_data  in  data_t  ALU result
- i_ld_valid  in  1  LSU load response valid
- o_ld_ready  out  1  load response accepted when valid&ready
- i_ld_rd  in  reg_t  load destination register
- i_ld_funct3  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101
- i_ld_off  in  2  byte offset of the load address
- i_ld_rdata  in  data_t  raw 32-bit word from memory
- i_issue_ld  in  1  decode issues a load this cycle
- i_issue_rd  in  reg_t  rd of the issued load
- i_dec_rs1, i_dec_rs2, i_dec_rd  in  reg_t  operands of the instruction in decode
- o_stall  out  1  decode must stall
- o_issue_full  out  1  outstanding count == MAX_OUTST
- o_Wen  out  1  register file write enable
- o_Wnum  out  reg_t  register file write index
- o_Wd  out  data_t  register file write data

Behaviour:
- Reset: i_rstn sampled on posedge i_clk, synchronous, active-low. Clears o_Wen/o_Wnum/o_Wd to 0, hold_v to 0, all pending bits, and the outstanding counter. Reset mid-operation drops any held load and all scoreboard state.
- Write-port timing: o_Wen/o_Wnum/o_Wd are registered. A source selected in cycle N appears on the port in cycle N+1, for exactly one cycle unless reselected.
- Write selection, each cycle, in priority order:
  - (1) i_alu_valid with i_alu_rd != 0 -> ALU write.
  - (2) else hold_v -> load write from hold register, then hold_v clears.
  - (3) else o_Wen <= 0.
  - ALU writes to x0 are suppressed and do not block the hold drain.
- Hold register: single entry. o_ld_ready = ~hold_v, which is combinational from the flop and has no path from i_ld_valid.
  - On valid&ready, capture rd and formatted data; hold_v <= 1.
  - A load to x0 is accepted and counted, but not captured (hold_v stays 0).
- Minimum load latency: accepted at edge N, port write visible in cycle N+2. Each consecutive ALU-valid cycle adds one cycle.
- Load formatting:
  - byte = rdata[8*off +: 8]; half = rdata[16*off[1] +: 16], with off[0] ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata unchanged.
  - Undefined funct3 formats as LW.
- Scoreboard pending[31:1]:
  - Set on i_issue_ld with i_issue_rd != 0.
  - Cleared on the edge where that load's write is selected from the hold register.
  - Same register set and cleared on the same edge -> set wins.
  - pending[0] is constant 0.
- Outstanding counter:
  - +1 on i_issue_ld & ~o_issue_full.
  - -1 on load response accept (valid&ready), including rd=0.
  - Both on the same edge -> unchanged.
  - Saturating; issue while full is a protocol error that decode prevents and the bench asserts against.
- o_stall, combinational:
  - pending[i_dec_rs1] | pending[i_dec_rs2] | pending[i_dec_rd] (covers RAW and WAW), OR
  - o_issue_full.
  - o_stall does not depend on i_issue_ld in the same cycle.
- Load responses arrive in issue order; no tagging.

Decomposition:
- Shared package soin_pkg holds:
  - data_t (logic [31:0]) and reg_t (logic [4:0]).
  - N_REG = 32.
  - Load funct3 constants F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU.
- One natural sub-module: ld_format, the purely combinational funct3/offset extract-and-extend. Its output feeds the hold register.

Test Plan:
- Reset: assert i_rstn=0 for 2 cycles with ALU and load traffic active -> o_Wen=0, o_Wnum=0, o_Wd=0, o_ld_ready=1, o_stall=0, o_issue_full=0.
- ALU path:
  - alu_valid, rd=5, data=0xDEADBEEF at cycle N -> cycle N+1: o_Wen=1, o_Wnum=5, o_Wd=0xDEADBEEF; cycle N+2: o_Wen=0.
  - rd=0 -> o_Wen stays 0.
- Load formatting, rdata=0x80FF7F01:
  - LB off=3 -> 0xFFFFFF80
  - LBU off=1 -> 0x0000007F
  - LH off=2 -> 0xFFFF80FF
  - LHU off=0 -> 0x00007F01
  - LW -> 0x80FF7F01
- Conflict:
  - Load rd=7 accepted at N, alu_valid rd=3 during N+1 and N+2 -> ALU writes in N+2 and N+3, load write rd=7 in N+4.
  - o_ld_ready=0 during N+1..N+3.
- Scoreboard:
  - issue_ld rd=9 -> dec_rs1=9 gives o_stall=1, and stall remains until the load-9 write is selected.
  - Re-issue rd=9 on the same edge as the clear -> pending[9] stays 1.
- Outstanding limit:
  - 2 issues without responses -> o_issue_full=1, o_stall=1.
  - One response accepted -> o_issue_full=0 the next cycle.
  - Simultaneous issue+accept -> count unchanged.
